// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier datapath; one iteration per step_i, WIDTH iterations total.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  // result_o is the accumulator after the current iteration, so done_o and result_o line up
  assign result_o = acc_d;
  assign done_o   = step_i && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle ops plus a multi-cycle shift-add MUL that stalls upstream.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             stall_o
);

  import alu_pkg::*;

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             valid_q;

  logic [WIDTH-1:0] alu_res;
  logic [SH_W-1:0]  shamt;
  logic             accept;
  logic             mul_start, mul_step, mul_done;
  logic [WIDTH-1:0] mul_res;

  assign ready_o   = (state_q == IDLE);
  assign stall_o   = (state_q == MUL);
  assign accept    = valid_i && ready_o && !flush_i;
  assign mul_start = accept && (ctrl_i == ALU_MUL);
  assign mul_step  = stall_o && !flush_i;
  assign shamt     = data2_i[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_XOR: alu_res = data1_i ^ data2_i;
      ALU_SLL: alu_res = data1_i << shamt;
      ALU_SRA: alu_res = $unsigned($signed(data1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .step_i   (mul_step),
    .mcand_i  (data1_i),
    .mplier_i (data2_i),
    .done_o   (mul_done),
    .result_o (mul_res)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // flush aborts everything but leaves the last result visible
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              if (ctrl_i == ALU_MUL) begin
                state_q <= MUL;
              end else begin
                data_q  <= alu_res;
                zero_q  <= (alu_res == '0);
                valid_q <= 1'b1;
              end
            end
          end
          MUL: begin
            if (mul_done) begin
              data_q  <= mul_res;
              zero_q  <= (mul_res == '0);
              valid_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  ctrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;
  logic        stall_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  alu_mc #(.WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ctrl_i  (ctrl_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .flush_i (flush_i),
    .data_o  (data_o),
    .zero_o  (zero_o),
    .valid_o (valid_o),
    .stall_o (stall_o)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    int sh;
    sh = int'(b[4:0]);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a ^ b;
      3'd4: begin wide = {32'b0, a} * {32'b0, b}; return wide[31:0]; end
      3'd5: return a << sh;
      3'd6: begin wide = {{32{a[31]}}, a} >> sh; return wide[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp;
    int stalls;
    int early;
    exp = ref_alu(c, a, b);
    ctrl_i = c; data1_i = a; data2_i = b; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    if (c == 3'd4) begin
      stalls = 0;
      early = 0;
      while (stall_o && stalls < 40) begin
        stalls++;
        if (valid_o) early++;
        valid_i = 1'($urandom_range(0, 1));
        ctrl_i  = 3'($urandom_range(0, 7));
        data1_i = $urandom;
        @(negedge clk_i);
      end
      valid_i = 1'b0;
      vectors++;
      if (stalls !== 32) begin
        miscompares++;
        $display("FAIL %s stall_cycles got %0d want 32", name, stalls);
      end
      vectors++;
      if (early !== 0) begin
        miscompares++;
        $display("FAIL %s valid_during_stall got %0d want 0", name, early);
      end
    end
    vectors++;
    if (valid_o !== 1'b1 || data_o !== exp || zero_o !== (exp == 32'd0)) begin
      miscompares++;
      $display("FAIL %s result got v=%b d=%h z=%b want v=1 d=%h z=%b", name, valid_o, data_o, zero_o, exp, exp == 32'd0);
    end
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s pulse_end got v=%b rdy=%b want v=0 rdy=1", name, valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (data_o !== 32'd0 || zero_o !== 1'b1 || valid_o !== 1'b0 || ready_o !== 1'b1 || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got d=%h z=%b v=%b rdy=%b st=%b want 0/1/0/1/0", data_o, zero_o, valid_o, ready_o, stall_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd5, 32'd7, "add_5_7");
    run_op(3'd1, 32'd3, 32'd3, "sub_3_3");
    run_op(3'd6, 32'h8000_0000, 32'h24, "sra_shamt4");
    run_op(3'd5, 32'd1, 32'd31, "sll_1_31");
    run_op(3'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
    run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
    run_op(3'd4, 32'hFFFF_FFFF, 32'd3, "mul_m1_3");
  endtask

  task automatic test_back_to_back();
    int n;
    ctrl_i = 3'd4; data1_i = 32'd1234; data2_i = 32'd5678; valid_i = 1'b1;
    @(negedge clk_i);
    ctrl_i = 3'd0; data1_i = 32'd1; data2_i = 32'd1;
    n = 0;
    while (!valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 32'd7006652) begin
      miscompares++;
      $display("FAIL b2b_mul got v=%b d=%0d want v=1 d=7006652", valid_o, data_o);
    end
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_add got v=%b d=%0d want v=1 d=2", valid_o, data_o);
    end
    valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_flush();
    int seen;
    run_op(3'd0, 32'd5, 32'd7, "flush_pre");
    ctrl_i = 3'd4; data1_i = 32'd99; data2_i = 32'd77; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    vectors++;
    if (ready_o !== 1'b1 || stall_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'd12) begin
      miscompares++;
      $display("FAIL flush_mul got rdy=%b st=%b v=%b d=%0d want 1/0/0/12", ready_o, stall_o, valid_o, data_o);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL flush_no_result got %0d pulses want 0", seen);
    end
    ctrl_i = 3'd0; data1_i = 32'd9; data2_i = 32'd9; valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 32'd12) begin
      miscompares++;
      $display("FAIL flush_vs_valid got v=%b d=%0d want v=0 d=12", valid_o, data_o);
    end
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_vs_valid_late got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    run_op(3'd0, 32'd5, 32'd7, "rst_pre");
    ctrl_i = 3'd4; data1_i = 32'd1234; data2_i = 32'd5678; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    vectors++;
    if (data_o !== 32'd0 || zero_o !== 1'b1 || valid_o !== 1'b0 || ready_o !== 1'b1 || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mul got d=%h z=%b v=%b rdy=%b st=%b want 0/1/0/1/0", data_o, zero_o, valid_o, ready_o, stall_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_no_result got %0d pulses want 0", seen);
    end
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1234_5678, "rsvd");
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(c, a, b, "random");
    end
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    ctrl_i = 3'd0; data1_i = 32'd0; data2_i = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
